// File: rtl/servo_pkg.sv
// ============================================================================
// servo_pkg : shared widths, channel count and reset defaults for servo_ramp
// Rev 1.0
// ============================================================================
`default_nettype none

package servo_pkg;
  localparam int PER_W = 23;
  localparam int PW_W  = 18;
  localparam int NCH   = 2;

  localparam logic [PER_W-1:0] T_RST = 23'd999_999;
  localparam logic [PW_W-1:0]  D_RST = 18'd75_000;
endpackage

`default_nettype wire

// File: rtl/servo_ramp_ch.sv
// ============================================================================
// servo_ramp_ch : one servo channel -- frame counter, pending command, slew step
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter logic [PER_W-1:0] T_INIT = T_RST,
  parameter logic [PW_W-1:0]  D_INIT = D_RST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PER_W-1:0] cfg_period,
  input  logic             cmd_we,
  input  logic [PW_W-1:0]  cmd_target,
  input  logic [PW_W-1:0]  cmd_step,
  output logic             pend,
  output logic [PER_W-1:0] per,
  output logic [PW_W-1:0]  cur,
  output logic             busy,
  output logic             done
);

  logic [PER_W-1:0] fcnt_q, fcnt_d, per_q, per_d;
  logic [PW_W-1:0]  cur_q, cur_d, tgt_q, tgt_d, step_q, step_d;
  logic [PW_W-1:0]  ptgt_q, ptgt_d, pstep_q, pstep_d;
  logic             pv_q, pv_d, busy_q, busy_d, done_q, done_d;

  logic             boundary;
  logic [PW_W-1:0]  tgt_eff, step_eff;
  logic [PW_W:0]    sum, diff;

  always_comb begin
    boundary = (fcnt_q == per_q);
    fcnt_d   = fcnt_q + PER_W'(1);
    per_d    = per_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    pv_d     = pv_q;
    ptgt_d   = ptgt_q;
    pstep_d  = pstep_q;

    // A pending target is clamped against the period that takes effect now
    tgt_eff  = tgt_q;
    step_eff = step_q;
    if (pv_q) begin
      tgt_eff  = ({{(PER_W-PW_W){1'b0}}, ptgt_q} > cfg_period) ? cfg_period[PW_W-1:0] : ptgt_q;
      step_eff = pstep_q;
    end

    sum  = {1'b0, cur_q} + {1'b0, step_eff};
    diff = {1'b0, cur_q} - {1'b0, step_eff};

    if (boundary) begin
      fcnt_d = '0;
      per_d  = cfg_period;
      tgt_d  = tgt_eff;
      step_d = step_eff;
      pv_d   = 1'b0;
      if (step_eff == '0) begin
        cur_d = tgt_eff;
      end else if (cur_q < tgt_eff) begin
        cur_d = (sum > {1'b0, tgt_eff}) ? tgt_eff : sum[PW_W-1:0];
      end else if (cur_q > tgt_eff) begin
        // diff[PW_W] set means the subtraction wrapped below zero
        cur_d = (diff[PW_W] || (diff[PW_W-1:0] < tgt_eff)) ? tgt_eff : diff[PW_W-1:0];
      end
    end

    if (cmd_we) begin
      pv_d    = 1'b1;
      ptgt_d  = cmd_target;
      pstep_d = cmd_step;
    end

    busy_d = (cur_d != tgt_d);
    done_d = busy_q && !busy_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q  <= '0;
      per_q   <= T_INIT;
      cur_q   <= D_INIT;
      tgt_q   <= D_INIT;
      step_q  <= '0;
      pv_q    <= 1'b0;
      ptgt_q  <= '0;
      pstep_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      per_q   <= per_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      pv_q    <= pv_d;
      ptgt_q  <= ptgt_d;
      pstep_q <= pstep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pend = pv_q;
  assign per  = per_q;
  assign cur  = cur_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/servo_ramp.sv
// ============================================================================
// servo_ramp : two-channel slew-limited command stage feeding the servo PWM
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_ramp #(
  parameter logic [servo_pkg::PER_W-1:0] T_RST = servo_pkg::T_RST,
  parameter logic [servo_pkg::PW_W-1:0]  D_RST = servo_pkg::D_RST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [servo_pkg::PER_W-1:0] cfg_period0,
  input  logic [servo_pkg::PER_W-1:0] cfg_period1,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_ch,
  input  logic [servo_pkg::PW_W-1:0]  cmd_target,
  input  logic [servo_pkg::PW_W-1:0]  cmd_step,
  output logic [servo_pkg::PER_W-1:0] T0,
  output logic [servo_pkg::PER_W-1:0] T1,
  output logic [servo_pkg::PW_W-1:0]  D0,
  output logic [servo_pkg::PW_W-1:0]  D1,
  output logic                        busy0,
  output logic                        busy1,
  output logic                        done0,
  output logic                        done1
);

  import servo_pkg::*;

  logic [PER_W-1:0] cfg [NCH];
  logic [PER_W-1:0] per [NCH];
  logic [PW_W-1:0]  pw  [NCH];
  logic [NCH-1:0]   pend, we, busy, done;

  assign cfg[0] = cfg_period0;
  assign cfg[1] = cfg_period1;

  assign cmd_ready = ~pend[cmd_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign we[i] = cmd_valid && cmd_ready && (cmd_ch == 1'(i));

    servo_ramp_ch #(
      .T_INIT (T_RST),
      .D_INIT (D_RST)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cfg_period (cfg[i]),
      .cmd_we     (we[i]),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .pend       (pend[i]),
      .per        (per[i]),
      .cur        (pw[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

  assign T0    = per[0];
  assign T1    = per[1];
  assign D0    = pw[0];
  assign D1    = pw[1];
  assign busy0 = busy[0];
  assign busy1 = busy[1];
  assign done0 = done[0];
  assign done1 = done[1];

endmodule

`default_nettype wire

// File: doc/servo_ramp.md
# servo_ramp

Slew-rate-limited command stage that drives the two-channel servo PWM generator. It accepts per-channel target pulse widths and step sizes over a valid/ready handshake. It ramps each channel's current pulse width toward its target by at most one step per PWM frame. It presents the result as the generator's period (T0/T1) and duty (D0/D1) inputs, updating only at frame boundaries so that no PWM period is ever truncated.

## Interface
- `T_RST`, 23'd999_999: reset/initial period per channel (20 ms at 50 MHz, frame = T+1 cycles).
- `D_RST`, 18'd75_000: reset/initial pulse width per channel (1.5 ms).
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_period0`, `cfg_period1`  in  23  requested frame period per channel, sampled at that channel's frame boundary.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_ch`  in  1  target channel (0/1).
- `cmd_target`  in  18  requested pulse width in cycles.
- `cmd_step`  in  18  maximum change per frame; 0 = jump directly to target.
- `T0`, `T1`  out  23  period to PWM generator.
- `D0`, `D1`  out  18  pulse width to PWM generator.
- `busy0`, `busy1`  out  1  high while current ≠ target.
- `done0`, `done1`  out  1  one-cycle pulse when current reaches target.

## Operation
- Each channel holds the following registers:
  - `fcnt` (23 b) frame counter.
  - `per` (= T output).
  - `cur` (= D output).
  - `tgt`, `step`.
  - A one-entry pending buffer (`pv`, `ptgt`, `pstep`).
- Reset values:
  - `fcnt`=0, `per`=T_RST, `cur`=`tgt`=D_RST, `step`=0, `pv`=0.
  - `busy`=0, `done`=0.
  - `cmd_ready`=1 after reset release.
- `cmd_ready` = `~pv[cmd_ch]` (combinational on `cmd_ch`).
- On handshake: `pv[ch]`←1, `ptgt`←`cmd_target`, `pstep`←`cmd_step`.
- Frame counter: counts 0..`per`, wraps to 0. The boundary is the cycle with `fcnt == per`.
- At a boundary, in order, all registered on that edge:
  1. `per` ← `cfg_period`.
  2. If `pv`: `tgt` ← min(`ptgt`, new `per`); `step` ← `pstep`; `pv` ← 0.
  3. Step `cur` toward the effective `tgt`, using the effective `step`:
     - `step`==0 → `cur`←`tgt`.
     - `cur`<`tgt` → `cur`←min(`cur`+`step`, `tgt`), computed in 19 b.
     - `cur`>`tgt` → `cur`←max(`cur`−`step`, `tgt`), computed in 19 b, no underflow.
- `busy` = registered (`cur` ≠ `tgt`). It is updated on the same edge as `cur`/`tgt`.
- `done` pulses for one cycle on the edge where `cur` becomes equal to `tgt` from unequal.
- A command whose target equals the current `cur` produces no `done`.
- Channels are fully independent; periods may differ.

## Timing
- New D/T appear the cycle after a boundary, coincident with the PWM generator's counter wrap to 0. Both blocks share reset, so the frames are aligned.
- Command latency: accepted command affects `D` at the next boundary of its channel. That is at most `per`+1 cycles after acceptance, plus one register.
- Handshake completing on a boundary cycle: the command is stored in pending and applies at the following boundary.
  - This cannot occur while `pv`=1, since `ready` is low then.
- A second command to a busy-pending channel stalls (`ready`=0) until the next boundary clears `pv`. Commands to the other channel proceed.
- Period change takes effect on the same boundary. `fcnt` restarts at 0 and counts to the new `per`.
- Reset asserted mid-ramp restores all reset values immediately (async) and discards pending commands.

## Structure
- Shared package `servo_pkg`:
  - Width constants: PER_W=23, PW_W=18.
  - Reset defaults T_RST, D_RST.
  - Channel-count constant NCH=2.
- Natural sub-module: `servo_ramp_ch`, one channel containing frame counter, pending buffer, slew arithmetic, busy/done.
- Top instantiates two channels and does `cmd_ch` demux and `cmd_ready` mux.

## Test plan
- **Reset check:** reset, `cfg_period0`=99 → T0=999_999, D0=75_000 until the first boundary at cycle 1_000_000.
  - Use T_RST=99, D_RST=50 in the bench for speed.
- **Up-ramp:** T=99, cur=50, cmd ch0 target 80 step 10 → D0 = 60, 70, 80 on three successive boundaries, 100 cycles apart.
  - `done0` pulses once with D0=80; `busy0` is high between.
- **Down-ramp with clamp and jump:**
  - cur=80, target 5 step 30 → D0 = 50, 20, 5 with no underflow.
  - Then target 200 step 0 → D0=99 (clamped to period) at the next boundary.
- **Backpressure:** two ch0 commands back to back → first accepted, `cmd_ready` low until the boundary.
  - A ch1 command in the stall window is accepted immediately.
  - The second ch0 command applies one frame later.
- **Boundary race:** handshake on a cycle with `fcnt0`==`per` → D0 unchanged at that boundary and updated at the next.
  - `cfg_period0` changed 99→49 mid-frame → the next frame is 50 cycles long.
- **Async reset mid-ramp:** `rst` low during a ramp between clock edges → outputs return to reset values without a clock edge, pending is cleared, and `cmd_ready`=1 after release.
